// File: rtl/demux_sched_pkg.sv
// Shared constants and types for the 1:8 demux sequencing controller.
package demux_sched_pkg;
    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic MODE_DEST = 1'b0;
    localparam logic MODE_RR   = 1'b1;
endpackage

// File: rtl/rr_next_lane.sv
// Rotating-priority search: first set bit of mask starting at ptr, wrapping 7->0.
module rr_next_lane
    import demux_sched_pkg::*;
(
    input  logic [SEL_W-1:0]   ptr,
    input  logic [N_LANES-1:0] mask,
    output logic [SEL_W-1:0]   lane,
    output logic               found
);

    logic [SEL_W-1:0] cand [N_LANES];

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_cand
            assign cand[gi] = ptr + SEL_W'(gi);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest enabled lane wins.
    always_comb begin
        lane  = ptr;
        found = 1'b0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (mask[cand[i]]) begin
                lane  = cand[i];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// Valid/ready sequencer steering each input word to one of 8 lanes through a
// one-entry holding register, with saturating sent/drop statistics.
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [SEL_W-1:0]    in_dest,
    input  logic                rr_mode,
    input  logic [N_LANES-1:0]  lane_en,
    output logic [DATA_W-1:0]   out_data,
    output logic [N_LANES-1:0]  out_valid,
    input  logic [N_LANES-1:0]  out_ready,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic [CNT_W-1:0]    sent_cnt,
    output logic [7:0]          drop_cnt
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic [7:0]          drop_q, drop_d;

    logic [SEL_W-1:0]    rr_lane;
    logic                rr_found;
    logic                drain;
    logic                legal;
    logic                accept;
    logic                dropped;
    logic [SEL_W-1:0]    target;

    rr_next_lane u_rr_next_lane (
        .ptr   (rr_ptr_q),
        .mask  (lane_en),
        .lane  (rr_lane),
        .found (rr_found)
    );

    assign drain    = (state_q == HOLD) && out_ready[sel_q];
    // Dest mode always takes the word: an unusable destination means a drop.
    assign legal    = (rr_mode == MODE_RR) ? rr_found : 1'b1;
    assign in_ready = ((state_q == IDLE) || drain) && legal;
    assign accept   = in_valid && in_ready;
    assign target   = (rr_mode == MODE_RR) ? rr_lane : in_dest;
    assign dropped  = accept && (rr_mode == MODE_DEST) && !lane_en[in_dest];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        data_d   = data_q;
        sent_d   = sent_q;
        drop_d   = drop_q;

        if (drain && (sent_q != '1)) begin
            sent_d = sent_q + 1'b1;
        end
        if (dropped && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end

        if (accept && !dropped) begin
            state_d = HOLD;
            sel_d   = target;
            data_d  = in_data;
            if (rr_mode == MODE_RR) begin
                rr_ptr_d = target + 1'b1;
            end
        end else if (drain) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            sent_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            sent_q   <= sent_d;
            drop_q   <= drop_d;
        end
    end

    assign out_valid = (state_q == HOLD) ? (N_LANES'(1) << sel_q) : '0;
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign busy      = (state_q == HOLD);
    assign sent_cnt  = sent_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_sched.sv
// Directed self-checking bench for demux_sched.
module tb_demux_sched;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_dest;
    logic        rr_mode;
    logic [7:0]  lane_en;
    logic [7:0]  out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [2:0]  sel;
    logic        busy;
    logic [15:0] sent_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    demux_sched #(.DATA_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .rr_mode   (rr_mode),
        .lane_en   (lane_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy),
        .sent_cnt  (sent_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_dest   = 3'd0;
        rr_mode   = 1'b1;
        lane_en   = 8'hFF;
        out_ready = 8'hFF;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_sel", 32'(sel), 32'h0);
        chk("reset_sent", 32'(sent_cnt), 32'h0);
        chk("reset_drop", 32'(drop_cnt), 32'h0);
        rst_n = 1'b1;

        // Round-robin at full throughput, lanes 0..7.
        in_valid = 1'b1;
        in_data  = 8'h10;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rr_full_valid%0d", k), 32'(out_valid), 32'(8'h01 << k));
            chk($sformatf("rr_full_data%0d", k), 32'(out_data), 32'(8'h10 + k));
            chk($sformatf("rr_full_ready%0d", k), 32'(in_ready), 32'h1);
            $display("rr_full word %0d lane_valid=%02h data=%02h", k, out_valid, out_data);
            in_data = 8'(8'h11 + k);
            if (k == 7) in_valid = 1'b0;
        end
        tick();
        chk("rr_full_idle", 32'(out_valid), 32'h00);
        chk("rr_full_sent", 32'(sent_cnt), 32'd8);

        // Skip disabled lanes: 0x25 -> lanes 0,2,5,0.
        lane_en  = 8'h25;
        in_valid = 1'b1;
        in_data  = 8'h20;
        tick(); chk("skip_v0", 32'(out_valid), 32'h01); chk("skip_s0", 32'(sel), 32'd0);
        in_data = 8'h21;
        tick(); chk("skip_v1", 32'(out_valid), 32'h04); chk("skip_s1", 32'(sel), 32'd2);
        in_data = 8'h22;
        tick(); chk("skip_v2", 32'(out_valid), 32'h20); chk("skip_s2", 32'(sel), 32'd5);
        in_data = 8'h23;
        tick(); chk("skip_v3", 32'(out_valid), 32'h01); chk("skip_d3", 32'(out_data), 32'h23);
        $display("skip sequence done sel=%0d", sel);
        in_valid = 1'b0;
        tick(); chk("skip_idle", 32'(busy), 32'h0);
        lane_en  = 8'h00;
        in_valid = 1'b1;
        in_data  = 8'h24;
        #1; chk("no_lane_ready", 32'(in_ready), 32'h0);
        lane_en = 8'hFF;
        #1; chk("any_lane_ready", 32'(in_ready), 32'h1);
        tick(); chk("rr_ptr_resume", 32'(out_valid), 32'h02);
        $display("rr_ptr resume lane_valid=%02h", out_valid);
        in_valid = 1'b0;
        tick(); chk("skip_sent", 32'(sent_cnt), 32'd13);

        // Destination mode with a dropped word.
        rr_mode  = 1'b0;
        lane_en  = 8'hF7;
        in_valid = 1'b1;
        in_dest  = 3'd3;
        in_data  = 8'h30;
        #1; chk("dest_ready", 32'(in_ready), 32'h1);
        tick();
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
        chk("drop_no_valid", 32'(out_valid), 32'h00);
        chk("drop_not_busy", 32'(busy), 32'h0);
        $display("dest 3 dropped drop_cnt=%0d", drop_cnt);
        in_dest = 3'd6;
        in_data = 8'h31;
        tick();
        chk("dest6_valid", 32'(out_valid), 32'h40);
        chk("dest6_sel", 32'(sel), 32'd6);
        chk("dest6_data", 32'(out_data), 32'h31);
        $display("dest 6 lane_valid=%02h sel=%0d", out_valid, sel);
        in_valid = 1'b0;
        tick(); chk("dest_sent", 32'(sent_cnt), 32'd14);

        // Backpressure on lane 4.
        rr_mode   = 1'b1;
        lane_en   = 8'h10;
        out_ready = 8'hEF;
        in_valid  = 1'b1;
        in_data   = 8'h40;
        tick();
        in_data = 8'h41;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'h10);
            chk($sformatf("bp_data%0d", k), 32'(out_data), 32'h40);
            chk($sformatf("bp_ready%0d", k), 32'(in_ready), 32'h0);
            chk($sformatf("bp_busy%0d", k), 32'(busy), 32'h1);
            $display("backpressure cycle %0d lane_valid=%02h", k, out_valid);
            tick();
        end
        out_ready = 8'hFF;
        #1; chk("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bp_next_valid", 32'(out_valid), 32'h10);
        chk("bp_next_data", 32'(out_data), 32'h41);
        chk("bp_sent", 32'(sent_cnt), 32'd15);
        in_valid = 1'b0;
        tick(); chk("bp_sent2", 32'(sent_cnt), 32'd16);

        // Mode/enable change while holding a word on lane 2.
        lane_en   = 8'h04;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_data   = 8'h50;
        tick();
        in_valid = 1'b0;
        chk("mid_valid", 32'(out_valid), 32'h04);
        lane_en = 8'hFB;
        rr_mode = 1'b0;
        tick();
        chk("mid_still_valid", 32'(out_valid), 32'h04);
        chk("mid_still_sel", 32'(sel), 32'd2);
        chk("mid_still_data", 32'(out_data), 32'h50);
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_dest   = 3'd5;
        in_data   = 8'h51;
        tick();
        chk("mid_new_valid", 32'(out_valid), 32'h20);
        chk("mid_new_data", 32'(out_data), 32'h51);
        chk("mid_sent", 32'(sent_cnt), 32'd17);
        $display("mid-hold change delivered, new lane_valid=%02h", out_valid);
        in_dest = 3'd2;
        in_data = 8'h52;
        tick();
        chk("drain_drop_idle", 32'(busy), 32'h0);
        chk("drain_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("drain_drop_sent", 32'(sent_cnt), 32'd18);
        in_valid = 1'b0;

        // Asynchronous reset while busy.
        rr_mode   = 1'b1;
        lane_en   = 8'hFF;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_data   = 8'h60;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'h1);
        chk("pre_reset_sel", 32'(sel), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h00);
        chk("async_rst_sel", 32'(sel), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_sent", 32'(sent_cnt), 32'd0);
        chk("async_rst_drop", 32'(drop_cnt), 32'd0);
        $display("async reset busy=%0d sent=%0d", busy, sent_cnt);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 8'h61;
        tick();
        chk("post_rst_lane0", 32'(out_valid), 32'h01);
        in_valid = 1'b0;
        tick();

        // Drop counter saturation.
        rr_mode  = 1'b0;
        lane_en  = 8'h00;
        in_dest  = 3'd0;
        in_valid = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        chk("drop_saturate", 32'(drop_cnt), 32'd255);
        chk("drop_sat_idle", 32'(out_valid), 32'h00);
        $display("drop saturation drop_cnt=%0d", drop_cnt);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
- Sequencing controller for the 1:8 demux datapath: accepts words on a valid/ready input stream and steers each to exactly one of 8 output lanes.
- Lane choice is either round-robin over enabled lanes or taken from a per-word destination field.
- One-entry holding register absorbs lane backpressure.
- Sits between a single producer and eight lane consumers; also keeps sent and dropped statistics.

Parameters:
- DATA_W, 8, payload width in bits.
- CNT_W, 16, width of the saturating sent counter (drop counter fixed at 8 bits).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer word valid.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  DATA_W  payload.
- in_dest  input  3  destination lane; used only when rr_mode=0.
- rr_mode  input  1  1 = round-robin, 0 = destination-addressed.
- lane_en  input  8  per-lane enable mask.
- out_data  output  DATA_W  payload of held word, shared by all lanes.
- out_valid  output  8  one-hot; bit k asserted while the held word targets lane k.
- out_ready  input  8  per-lane consumer ready.
- sel  output  3  index of the currently targeted lane, for the demux select.
- busy  output  1  holding register full.
- sent_cnt  output  CNT_W  completed output handshakes, saturating.
- drop_cnt  output  8  words dropped in dest mode, saturating.

Behaviour:
Interface:
- One clock, clk; reset rst_n is asynchronous and active-low.
- Reset value of every output and register is 0: state IDLE, rr_ptr=0, out_valid=0, sel=0, busy=0, both counters 0.

States:
- IDLE: holding register empty.
- HOLD: word latched, target lane fixed.

Ready and acceptance:
- in_ready = (IDLE or HOLD-draining) and a legal target exists.
- HOLD-draining means out_valid[sel] & out_ready[sel] in the current cycle.
- In rr_mode=1, a legal target exists only when lane_en != 0.
- In rr_mode=0, in_ready does not depend on lane_en.
- Accept = in_valid & in_ready.

Lane selection (evaluated at accept, combinational from the current inputs):
- rr_mode=1: target = first enabled lane searching rr_ptr, rr_ptr+1, ... with wrap 7->0.
  - On accept, rr_ptr <= target+1 mod 8.
- rr_mode=0, lane_en[in_dest]=1: target = in_dest; rr_ptr unchanged.
- rr_mode=0, lane_en[in_dest]=0: word is consumed, not latched, and drop_cnt increments (saturate at 255). State is unchanged unless a drain occurs in the same cycle.

Latency and output handshake:
- An accepted, non-dropped word is latched into out_data/sel and appears as out_valid[target]=1 on the next cycle (1-cycle latency); state -> HOLD.
- out_valid is one-hot or zero, never multi-hot. Only lane sel's ready matters; other out_ready bits are ignored.
- Handshake completes when out_valid[sel] & out_ready[sel]; sent_cnt increments (saturate at 2^CNT_W-1).
- If no accept happens in the same cycle, state -> IDLE and out_valid=0.

Simultaneous drain and accept:
- The new word replaces the old one with no bubble, giving full throughput of 1 word/cycle when the consumer is always ready.
- Drain plus a dropped accept: state -> IDLE and drop_cnt increments.

Boundary conditions:
- rr_mode or lane_en changes while in HOLD: the held word is still delivered to its latched lane, even if that lane is now disabled. The new settings apply from the next accept.
- in_data, in_dest, in_valid are ignored when in_ready=0. The producer must hold its word until accepted.
- Reset asserted mid-HOLD: the held word is discarded and all outputs return to 0 immediately (asynchronous).
- Counters hold at maximum; they never wrap.

Decomposition:
- Package demux_sched_pkg:
  - N_LANES=8, SEL_W=3.
  - State enum {IDLE, HOLD}.
  - Mode constants MODE_DEST=0, MODE_RR=1.
- Sub-module rr_next_lane: combinational rotating priority search.
  - Inputs: ptr[2:0], mask[7:0].
  - Outputs: lane[2:0], found.
  - Instantiated once.

Test Plan:
- Round-robin, consumers always ready: rr_mode=1, lane_en=0xFF, in_valid held high, words 0x10..0x17 -> one word per cycle; out_valid sequence 0x01,0x02,...,0x80 starting 1 cycle after first accept; sent_cnt=8.
- Skip disabled lanes: lane_en=0x25, 4 words -> lanes 0,2,5,0; rr_ptr=1 afterwards; lane_en=0x00 -> in_ready=0.
- Destination mode with drop: rr_mode=0, lane_en=0xF7, words with dest 3 then 6 -> dest-3 word dropped (drop_cnt=1, no out_valid); dest-6 word gives out_valid=0x40, sel=6.
- Backpressure: target out_ready[4]=0 for 5 cycles, out_ready to other lanes=1 -> out_valid=0x10 held stable, out_data stable, in_ready=0, busy=1. Release -> handshake, sent_cnt+1, next word accepted in the same cycle.
- Mid-HOLD change: in HOLD on lane 2, set lane_en[2]=0 and rr_mode=0 -> word still delivered on lane 2; next word follows the new mode.
- Reset mid-operation: assert rst_n=0 while busy=1 -> out_valid=0, sel=0, busy=0, counters 0 without waiting for a clock edge. After release, first round-robin word goes to lane 0.
